// File: rtl/multi_port_queue.sv
// Multi-lane in-order FIFO: up to ENQ_WIDTH pushes and DEQ_WIDTH pops per cycle, any depth.
// Optional `define MPQ_USAGE_OUT_EN exposes the occupancy count on usage_cnt_o.
module multi_port_queue #(
    parameter int unsigned ENTRY_COUNT = 8,
    parameter int unsigned ENQ_WIDTH   = 2,
    parameter int unsigned DEQ_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ENQ_WIDTH-1:0]            enq_vld_i,
    input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data_i,
    output logic [ENQ_WIDTH-1:0]            enq_rdy_o,
    output logic [DEQ_WIDTH-1:0]            deq_vld_o,
    output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data_o,
    input  logic [DEQ_WIDTH-1:0]            deq_rdy_i,
`ifdef MPQ_USAGE_OUT_EN
    output logic [$clog2(ENTRY_COUNT+1)-1:0] usage_cnt_o,
`endif
    input  logic                            flush_i
);

    localparam int unsigned PW = (ENTRY_COUNT > 1) ? $clog2(ENTRY_COUNT) : 1;
    localparam int unsigned CW = $clog2(ENTRY_COUNT + 1);

    logic [DATA_WIDTH-1:0] mem [ENTRY_COUNT];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         free;
    logic [CW-1:0]         enq_n;
    logic [CW-1:0]         deq_n;
    logic [ENQ_WIDTH-1:0]  enq_fire;

    // k never exceeds ENTRY_COUNT, so a single conditional subtract wraps any depth.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [CW-1:0] k);
        logic [PW:0] sum;
        sum = (PW+1)'(ptr) + (PW+1)'(k);
        if (sum >= (PW+1)'(ENTRY_COUNT)) begin
            sum = sum - (PW+1)'(ENTRY_COUNT);
        end
        return sum[PW-1:0];
    endfunction

    always_comb begin
        logic prefix;
        free      = CW'(ENTRY_COUNT) - cnt;
        prefix    = 1'b1;
        enq_n     = '0;
        enq_rdy_o = '0;
        enq_fire  = '0;
        for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
            enq_rdy_o[i] = ~flush_i & (free > CW'(i)) & prefix;
            prefix       = prefix & enq_vld_i[i];
            enq_fire[i]  = enq_vld_i[i] & enq_rdy_o[i];
            if (enq_fire[i]) begin
                enq_n = enq_n + CW'(1);
            end
        end
    end

    always_comb begin
        logic run;
        run       = 1'b1;
        deq_n     = '0;
        deq_vld_o = '0;
        for (int i = 0; i < int'(DEQ_WIDTH); i++) begin
            deq_vld_o[i] = ~flush_i & (cnt > CW'(i));
            // A consumer gap stops counting even if higher lanes are ready.
            if (run && deq_vld_o[i] && deq_rdy_i[i]) begin
                deq_n = deq_n + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < int'(DEQ_WIDTH); g++) begin : g_rd
        assign deq_data_o[g*DATA_WIDTH +: DATA_WIDTH] = mem[wrap_add(head, CW'(g))];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < int'(ENTRY_COUNT); i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < int'(ENQ_WIDTH); i++) begin
                if (enq_fire[i]) begin
                    mem[wrap_add(tail, CW'(i))] <= enq_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            head <= wrap_add(head, deq_n);
            tail <= wrap_add(tail, enq_n);
            cnt  <= cnt + enq_n - deq_n;
        end
    end

`ifdef MPQ_USAGE_OUT_EN
    assign usage_cnt_o = cnt;
`endif

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed bench for multi_port_queue at depth 6, two lanes each side, 16-bit payloads.
module tb_multi_port_queue;

    localparam int unsigned EC = 6;
    localparam int unsigned DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      enq_vld_i;
    logic [2*DW-1:0] enq_data_i;
    logic [1:0]      enq_rdy_o;
    logic [1:0]      deq_vld_o;
    logic [2*DW-1:0] deq_data_o;
    logic [1:0]      deq_rdy_i;
    logic            flush_i;
`ifdef MPQ_USAGE_OUT_EN
    logic [2:0]      usage_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    multi_port_queue #(
        .ENTRY_COUNT(EC),
        .ENQ_WIDTH  (2),
        .DEQ_WIDTH  (2),
        .DATA_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enq_vld_i  (enq_vld_i),
        .enq_data_i (enq_data_i),
        .enq_rdy_o  (enq_rdy_o),
        .deq_vld_o  (deq_vld_o),
        .deq_data_o (deq_data_o),
        .deq_rdy_i  (deq_rdy_i),
`ifdef MPQ_USAGE_OUT_EN
        .usage_cnt_o(usage_cnt_o),
`endif
        .flush_i    (flush_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic usage(input string tag, input int exp);
`ifdef MPQ_USAGE_OUT_EN
        chk(tag, 64'(usage_cnt_o), 64'(exp));
`else
        chk(tag, 64'(deq_vld_o), (exp >= 2) ? 64'h3 : 64'(exp));
`endif
    endtask

    task automatic lanes(input string tag, input logic [DW-1:0] l0, input logic [DW-1:0] l1);
        chk({tag, "_l0"}, 64'(deq_data_o[DW-1:0]), 64'(l0));
        chk({tag, "_l1"}, 64'(deq_data_o[2*DW-1:DW]), 64'(l1));
    endtask

    initial begin
        rst = 1'b0; enq_vld_i = 2'b00; enq_data_i = '0; deq_rdy_i = 2'b00; flush_i = 1'b0;
        #12;
        // Reset held
        chk("rst_deq_vld", 64'(deq_vld_o), 64'h0);
        chk("rst_deq_data", 64'(deq_data_o), 64'h0);
        chk("rst_enq_rdy", 64'(enq_rdy_o), 64'h1);
        usage("rst_cnt", 0);
        enq_vld_i = 2'b01; #1;
        chk("rst_enq_rdy_pfx", 64'(enq_rdy_o), 64'h3);
        enq_vld_i = 2'b00;
        @(negedge clk); rst = 1'b1;
        tick();
        chk("post_rst_deq_vld", 64'(deq_vld_o), 64'h0);
        chk("post_rst_deq_data", 64'(deq_data_o), 64'h0);

        // Fill with A..F
        enq_vld_i = 2'b11; enq_data_i = {16'h000B, 16'h000A}; #1;
        chk("fill_rdy0", 64'(enq_rdy_o), 64'h3);
        chk("fill_no_bypass", 64'(deq_vld_o), 64'h0);
        tick();
        chk("fill_vld1", 64'(deq_vld_o), 64'h3);
        lanes("fill1", 16'h000A, 16'h000B);
        enq_data_i = {16'h000D, 16'h000C};
        tick();
        enq_data_i = {16'h000F, 16'h000E}; #1;
        chk("fill_rdy_free2", 64'(enq_rdy_o), 64'h3);
        tick();
        enq_data_i = {16'h0099, 16'h0098}; #1;
        usage("full_cnt", 6);
        chk("full_enq_rdy", 64'(enq_rdy_o), 64'h0);
        lanes("full", 16'h000A, 16'h000B);

        // Full with pop: still not ready this cycle
        deq_rdy_i = 2'b11; #1;
        chk("full_pop_rdy", 64'(enq_rdy_o), 64'h0);
        deq_rdy_i = 2'b01;
        tick();
        deq_rdy_i = 2'b00;
        lanes("pop_a", 16'h000B, 16'h000C);
        usage("pop_a_cnt", 5);
        enq_vld_i = 2'b11; enq_data_i = {16'h0099, 16'h0010}; #1;
        chk("one_free_rdy", 64'(enq_rdy_o), 64'h1);
        tick();
        enq_vld_i = 2'b00;
        usage("wrap_cnt", 6);

        // Consumer gap blocks lane 1
        deq_rdy_i = 2'b10;
        tick();
        lanes("gap", 16'h000B, 16'h000C);
        usage("gap_cnt", 6);

        // Drain; G sits at index 0 after the tail wrap
        deq_rdy_i = 2'b11;
        tick();
        lanes("drain1", 16'h000D, 16'h000E);
        tick();
        lanes("drain2", 16'h000F, 16'h0010);
        tick();
        deq_rdy_i = 2'b00;
        chk("drained_vld", 64'(deq_vld_o), 64'h0);

        // Enqueue gap: lane 1 alone is refused
        enq_vld_i = 2'b10; enq_data_i = {16'h0077, 16'h0066}; #1;
        chk("enq_gap_rdy", 64'(enq_rdy_o), 64'h1);
        tick();
        chk("enq_gap_none", 64'(deq_vld_o), 64'h0);

        // Simultaneous enqueue/dequeue at cnt=3
        enq_vld_i = 2'b11; enq_data_i = {16'h0021, 16'h0020};
        tick();
        enq_vld_i = 2'b01; enq_data_i = {16'h0099, 16'h0022};
        tick();
        usage("sim_cnt3", 3);
        lanes("sim_pre", 16'h0020, 16'h0021);
        enq_vld_i = 2'b11; enq_data_i = {16'h0024, 16'h0023}; deq_rdy_i = 2'b11;
        tick();
        enq_vld_i = 2'b00; deq_rdy_i = 2'b00;
        usage("sim_cnt_hold", 3);
        lanes("sim_post", 16'h0022, 16'h0023);
        deq_rdy_i = 2'b01;
        tick();
        lanes("sim_pop1", 16'h0023, 16'h0024);

        // Build cnt=4 then flush
        deq_rdy_i = 2'b00; enq_vld_i = 2'b11; enq_data_i = {16'h0026, 16'h0025};
        tick();
        usage("pre_flush_cnt", 4);
        flush_i = 1'b1; enq_vld_i = 2'b11; deq_rdy_i = 2'b11; #1;
        chk("flush_enq_rdy", 64'(enq_rdy_o), 64'h0);
        chk("flush_deq_vld", 64'(deq_vld_o), 64'h0);
        tick();
        flush_i = 1'b0; deq_rdy_i = 2'b00; #1;
        usage("post_flush_cnt", 0);
        chk("post_flush_rdy", 64'(enq_rdy_o), 64'h3);
        enq_data_i = {16'h0031, 16'h0030};
        tick();
        lanes("post_flush", 16'h0030, 16'h0031);

        // Async reset mid-enqueue
        enq_data_i = {16'h0041, 16'h0040}; #2;
        rst = 1'b0; #1;
        chk("async_rst_vld", 64'(deq_vld_o), 64'h0);
        chk("async_rst_data", 64'(deq_data_o), 64'h0);
        usage("async_rst_cnt", 0);
        enq_vld_i = 2'b00;
        @(negedge clk); rst = 1'b1;
        tick();
        chk("after_async_vld", 64'(deq_vld_o), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
